wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 15 +
 rtl/wb_port_arbiter_if.sv | 30 +++
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-port bus: MEM/WB source A, long-latency source B, register-file side.
interface wb_port_arbiter_if
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              a_we_i;
  logic [ADDR_W-1:0] a_rd_i;
  logic [DATA_W-1:0] a_data_i;
  logic              b_valid_i;
  logic              b_ready_o;
  logic [ADDR_W-1:0] b_rd_i;
  logic [DATA_W-1:0] b_data_i;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_data_o;
  logic              stall_o;
  logic              kill_o;

  modport master (
    output a_we_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
    input  b_ready_o, rf_we_o, rf_addr_o, rf_data_o, stall_o, kill_o
  );

  modport slave (
    input  a_we_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
    output b_ready_o, rf_we_o, rf_addr_o, rf_data_o, stall_o, kill_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between MEM/WB writeback (A)
// and a one-entry buffered long-latency result stream (B) with bounded wait.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_port_arbiter_if.slave   bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              stall_q, b_ready_q;

  logic              a_act;
  logic              a_hits_buf;
  logic [3:0]        wait_inc;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              kill;

  assign a_act      = bus.a_we_i && (bus.a_rd_i != REG_ZERO);
  assign a_hits_buf = (bus.a_rd_i == buf_rd_q);
  assign wait_inc   = wait_cnt_q + 4'd1;

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = bus.a_rd_i;
    rf_data = bus.a_data_i;
    kill    = 1'b0;
    unique case (state_q)
      IDLE: rf_we = a_act;
      PEND: begin
        rf_we = 1'b1;
        if (a_act) begin
          // A is younger, so a same-rd write makes the buffered result dead.
          kill = a_hits_buf;
        end else begin
          rf_addr = buf_rd_q;
          rf_data = buf_data_q;
        end
      end
      FORCE: begin
        rf_we   = 1'b1;
        rf_addr = buf_rd_q;
        rf_data = buf_data_q;
      end
      default: rf_we = 1'b0;
    endcase
    if (rst_i) begin
      rf_we = 1'b0;
      kill  = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        // x0 results complete the handshake but are never buffered.
        if (bus.b_valid_i && (bus.b_rd_i != REG_ZERO)) begin
          state_d    = PEND;
          buf_rd_d   = bus.b_rd_i;
          buf_data_d = bus.b_data_i;
          wait_cnt_d = 4'd0;
        end
      end
      PEND: begin
        if (!a_act || a_hits_buf) begin
          state_d    = IDLE;
          buf_rd_d   = '0;
          buf_data_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == MAX_WAIT_C) state_d = FORCE;
        end
      end
      FORCE: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
        buf_rd_d   = '0;
        buf_data_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      wait_cnt_q <= 4'd0;
      stall_q    <= 1'b0;
      b_ready_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= (state_d == FORCE);
      b_ready_q  <= (state_d == IDLE);
    end
  end

  assign bus.rf_we_o   = rf_we;
  assign bus.rf_addr_o = rf_addr;
  assign bus.rf_data_o = rf_data;
  assign bus.kill_o    = kill;
  assign bus.stall_o   = stall_q;
  assign bus.b_ready_o = b_ready_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vectors, reset corners, and random traffic
// against a pending-result model on MAX_WAIT=4 and MAX_WAIT=1 instances.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0.slave));
  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        a_we;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
    logic        e_kill;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a_we, input logic [4:0] a_rd, input logic [31:0] a_data,
                       input logic b_valid, input logic [4:0] b_rd, input logic [31:0] b_data);
    if0.a_we_i = a_we;  if0.a_rd_i = a_rd;  if0.a_data_i = a_data;
    if0.b_valid_i = b_valid; if0.b_rd_i = b_rd; if0.b_data_i = b_data;
    if1.a_we_i = a_we;  if1.a_rd_i = a_rd;  if1.a_data_i = a_data;
    if1.b_valid_i = b_valid; if1.b_rd_i = b_rd; if1.b_data_i = b_data;
  endtask

  // Reference model: a pending B result, how many times it has been passed
  // over, and whether the next cycle is the forced (stalling) write.
  logic        m_pend  [2];
  logic [4:0]  m_rd    [2];
  logic [31:0] m_data  [2];
  int          m_denied[2];
  logic        m_force [2];
  int          m_max   [2];

  task automatic check_inst(input int i, input string tag);
    logic a_act, e_we, e_stall, e_ready, e_kill;
    logic [4:0] e_addr;
    logic [31:0] e_data;
    logic g_we, g_stall, g_ready, g_kill;
    logic [4:0] g_addr;
    logic [31:0] g_data;
    if (i == 0) begin
      g_we = if0.rf_we_o; g_addr = if0.rf_addr_o; g_data = if0.rf_data_o;
      g_stall = if0.stall_o; g_ready = if0.b_ready_o; g_kill = if0.kill_o;
    end else begin
      g_we = if1.rf_we_o; g_addr = if1.rf_addr_o; g_data = if1.rf_data_o;
      g_stall = if1.stall_o; g_ready = if1.b_ready_o; g_kill = if1.kill_o;
    end
    a_act = if0.a_we_i && (if0.a_rd_i != 5'd0);
    e_kill = 1'b0; e_stall = 1'b0; e_ready = 1'b0;
    e_addr = if0.a_rd_i; e_data = if0.a_data_i; e_we = a_act;
    if (m_force[i]) begin
      e_stall = 1'b1; e_we = 1'b1; e_addr = m_rd[i]; e_data = m_data[i];
    end else if (!m_pend[i]) begin
      e_ready = 1'b1;
    end else if (!a_act) begin
      e_we = 1'b1; e_addr = m_rd[i]; e_data = m_data[i];
    end else begin
      e_kill = (if0.a_rd_i == m_rd[i]);
    end
    check({tag, "_we"}, 32'(g_we), 32'(e_we));
    check({tag, "_stall"}, 32'(g_stall), 32'(e_stall));
    check({tag, "_ready"}, 32'(g_ready), 32'(e_ready));
    check({tag, "_kill"}, 32'(g_kill), 32'(e_kill));
    if (e_we) begin
      check({tag, "_addr"}, 32'(g_addr), 32'(e_addr));
      check({tag, "_data"}, g_data, e_data);
    end
    // advance the model to the next cycle
    if (m_force[i]) begin
      m_force[i] = 1'b0; m_pend[i] = 1'b0; m_denied[i] = 0;
    end else if (!m_pend[i]) begin
      if (if0.b_valid_i && if0.b_rd_i != 5'd0) begin
        m_pend[i] = 1'b1; m_rd[i] = if0.b_rd_i; m_data[i] = if0.b_data_i; m_denied[i] = 0;
      end
    end else if (!a_act || e_kill) begin
      m_pend[i] = 1'b0;
    end else begin
      m_denied[i]++;
      if (m_denied[i] == m_max[i]) m_force[i] = 1'b1;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h33,   1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEAD, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd1, 32'h11,   1'b0, 5'd0, 32'h0,    1'b1, 5'd1, 32'h11,   1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 32'h22,   1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h33,   1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h44,   1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 5'd5, 32'h55,   1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h7777, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'd5, 32'h55,   1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h55,   1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hAAAA, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 5'd0, 32'hBBBB, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0};

    // Reset held with a live A write: nothing may reach the register file.
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", 32'(if0.rf_we_o), 32'd0);
    check("rst_ready", 32'(if0.b_ready_o), 32'd1);
    check("rst_stall", 32'(if0.stall_o), 32'd0);
    check("rst_kill", 32'(if0.kill_o), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].a_we, vecs[v].a_rd, vecs[v].a_data,
            vecs[v].b_valid, vecs[v].b_rd, vecs[v].b_data);
      #1;
      check($sformatf("v%0d_we", v), 32'(if0.rf_we_o), 32'(vecs[v].e_we));
      check($sformatf("v%0d_stall", v), 32'(if0.stall_o), 32'(vecs[v].e_stall));
      check($sformatf("v%0d_ready", v), 32'(if0.b_ready_o), 32'(vecs[v].e_ready));
      check($sformatf("v%0d_kill", v), 32'(if0.kill_o), 32'(vecs[v].e_kill));
      if (vecs[v].e_we) begin
        check($sformatf("v%0d_addr", v), 32'(if0.rf_addr_o), 32'(vecs[v].e_addr));
        check($sformatf("v%0d_data", v), if0.rf_data_o, vecs[v].e_data);
      end
      @(negedge clk);
    end

    // Async reset while a result is buffered and has been passed over twice.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0C0);
    @(negedge clk);
    drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("pre_rst_we", 32'(if0.rf_we_o), 32'd1);
    check("pre_rst_addr", 32'(if0.rf_addr_o), 32'd12);
    #1 rst = 1'b1;
    #1;
    check("arst_we", 32'(if0.rf_we_o), 32'd0);
    check("arst_ready", 32'(if0.b_ready_o), 32'd1);
    check("arst_stall", 32'(if0.stall_o), 32'd0);
    check("arst_kill", 32'(if0.kill_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("post_rst_we", 32'(if0.rf_we_o), 32'd0);
      check("post_rst_ready", 32'(if0.b_ready_o), 32'd1);
      @(negedge clk);
    end

    // Random traffic on both instances from a known-empty state.
    m_max[0] = 4;
    m_max[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0; m_force[i] = 1'b0; m_denied[i] = 0; m_rd[i] = '0; m_data[i] = '0;
    end
    for (int c = 0; c < 500; c++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom);
      #1;
      check_inst(0, "rnd0");
      check_inst(1, "rnd1");
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
